pipelined_data_memory: RTL

- Parametrised successor to the core's single-port word memory: byte-addressed RAM with a valid/ready request port, any-combination byte write mask and configurable read latency.
- Adds an optional post-reset clear sequencer, out-of-range error reporting and one memory-mapped IO word that drives LEDS.
- Sits between the multi-cycle RV32I core (load/store path) and the SOC top.

---
 rtl/pipelined_data_memory.sv | 77 +++++++
 1 files changed

// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: byte-addressed RAM (CLK, RESET, req_valid/req_ready, address, write_mask, write_data in; resp_valid, read_data, resp_error, LEDS out) with LATENCY-deep response pipeline, post-reset clear and one LEDS IO word
module pipelined_data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] IO_ADDR = 32'h0000_FFFC,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [3:0]  write_mask,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        resp_error,
  output logic [31:0] LEDS
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  typedef enum logic {CLEAR, READY} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] leds_q, leds_d;
  logic [LATENCY-1:0] pv_q, pe_q;
  logic [31:0] pd_q [LATENCY];
  logic acc, io_hit, ram_hit, wr, unused_ok;
  logic [AW-1:0] idx;
  logic [31:0] wmask, rdata;
  assign req_ready = (state_q == READY) && !RESET;
  assign acc = req_valid && req_ready;
  assign wr = |write_mask;
  assign io_hit = address[31:2] == IO_ADDR[31:2];
  assign ram_hit = 32'(address[31:2]) < DEPTH_WORDS;
  assign idx = address[AW+1:2];
  assign wmask = {{8{write_mask[3]}}, {8{write_mask[2]}}, {8{write_mask[1]}}, {8{write_mask[0]}}};
  assign rdata = wr ? '0 : io_hit ? leds_q : ram_hit ? mem[idx] : '0;
  assign unused_ok = ^address[1:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == AW'(DEPTH_WORDS - 1)) ? READY : CLEAR;
    end
    leds_d = (acc && io_hit) ? (leds_q & ~wmask) | (write_data & wmask) : leds_q;
  end
  always_ff @(posedge CLK)
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    else if (acc && ram_hit && wr) mem[idx] <= (mem[idx] & ~wmask) | (write_data & wmask);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q <= '0;
      leds_q <= '0;
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      leds_q <= leds_d;
      pv_q[0] <= acc;
      pe_q[0] <= acc && !io_hit && !ram_hit;
      pd_q[0] <= acc ? rdata : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  assign resp_valid = pv_q[LATENCY-1];
  assign resp_error = pe_q[LATENCY-1];
  assign read_data = pd_q[LATENCY-1];
  assign LEDS = leds_q;
endmodule
